// File: rtl/alu_cmd_sequencer.sv
// Command front-end for the signed ALU: accepts one command, pulses the selected unit's enable,
// waits for that unit's flag (or a timeout) and holds the extended result on a response port.
module alu_cmd_sequencer #(
    parameter int unsigned In_Data_Width  = 8,
    parameter int unsigned Out_Width      = 2 * In_Data_Width,
    parameter int unsigned Timeout_Cycles = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [In_Data_Width-1:0] cmd_A,
    input  logic [In_Data_Width-1:0] cmd_B,
    input  logic [3:0]               cmd_fun,
    output logic [In_Data_Width-1:0] A,
    output logic [In_Data_Width-1:0] B,
    output logic [1:0]               Alu_fun,
    output logic                     arith_enable,
    output logic                     logic_enable,
    output logic                     cmp_enable,
    output logic                     shift_enable,
    input  logic [Out_Width-1:0]     arith_out,
    input  logic                     arith_flag,
    input  logic [In_Data_Width-1:0] logic_out,
    input  logic                     logic_flag,
    input  logic [2:0]               cmp_out,
    input  logic                     cmp_flag,
    input  logic [In_Data_Width-1:0] shift_out,
    input  logic                     shift_flag,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [Out_Width-1:0]     res_data,
    output logic                     res_err,
    output logic                     busy
);

    localparam int unsigned CntWidth = $clog2(Timeout_Cycles + 1);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    state_e                   state_q, state_d;
    logic [In_Data_Width-1:0] a_q, a_d, b_q, b_d;
    logic [1:0]               fun_q, fun_d;
    logic [1:0]               sel_q, sel_d;
    logic [CntWidth-1:0]      cnt_q, cnt_d;
    logic [Out_Width-1:0]     res_data_q, res_data_d;
    logic                     res_err_q, res_err_d;

    logic                     sel_flag;
    logic [Out_Width-1:0]     sel_result;
    logic [CntWidth-1:0]      cnt_inc;
    logic                     timed_out;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_q        <= '0;
            b_q        <= '0;
            fun_q      <= '0;
            sel_q      <= '0;
            cnt_q      <= '0;
            res_data_q <= '0;
            res_err_q  <= 1'b0;
        end else begin
            a_q        <= a_d;
            b_q        <= b_d;
            fun_q      <= fun_d;
            sel_q      <= sel_d;
            cnt_q      <= cnt_d;
            res_data_q <= res_data_d;
            res_err_q  <= res_err_d;
        end
    end

    // Only the selected unit's flag counts; the others are ignored.
    always_comb begin
        sel_flag   = 1'b0;
        sel_result = '0;
        unique case (sel_q)
            2'b00: begin
                sel_flag   = arith_flag;
                sel_result = arith_out;
            end
            2'b01: begin
                sel_flag   = logic_flag;
                sel_result = Out_Width'(logic_out);
            end
            2'b10: begin
                sel_flag   = cmp_flag;
                sel_result = Out_Width'(cmp_out);
            end
            2'b11: begin
                sel_flag   = shift_flag;
                sel_result = Out_Width'(shift_out);
            end
            default: ;
        endcase
    end

    assign cnt_inc   = cnt_q + CntWidth'(1);
    assign timed_out = (cnt_inc == CntWidth'(Timeout_Cycles));

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (cmd_valid) state_d = StIssue;
            StIssue: state_d = StWait;
            StWait:  if (sel_flag || timed_out) state_d = StResp;
            StResp:  if (res_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        a_d        = a_q;
        b_d        = b_q;
        fun_d      = fun_q;
        sel_d      = sel_q;
        cnt_d      = cnt_q;
        res_data_d = res_data_q;
        res_err_d  = res_err_q;
        unique case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    a_d   = cmd_A;
                    b_d   = cmd_B;
                    fun_d = cmd_fun[1:0];
                    sel_d = cmd_fun[3:2];
                end
            end
            StIssue: cnt_d = '0;
            StWait: begin
                if (sel_flag) begin
                    res_data_d = sel_result;
                    res_err_d  = 1'b0;
                end else begin
                    cnt_d = cnt_inc;
                    if (timed_out) begin
                        res_data_d = '0;
                        res_err_d  = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        cmd_ready    = (state_q == StIdle);
        busy         = (state_q != StIdle);
        res_valid    = (state_q == StResp);
        arith_enable = (state_q == StIssue) && (sel_q == 2'b00);
        logic_enable = (state_q == StIssue) && (sel_q == 2'b01);
        cmp_enable   = (state_q == StIssue) && (sel_q == 2'b10);
        shift_enable = (state_q == StIssue) && (sel_q == 2'b11);
        A            = a_q;
        B            = b_q;
        Alu_fun      = fun_q;
        res_data     = res_data_q;
        res_err      = res_err_q;
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer: execution-unit stubs, a transaction-level response model
// and a per-cycle compare process, plus hand-computed literal expectations.
module tb_alu_cmd_sequencer;

    logic        clk, rst;
    logic        cmd_valid, cmd_ready;
    logic [7:0]  cmd_A, cmd_B;
    logic [3:0]  cmd_fun;
    logic [7:0]  A, B;
    logic [1:0]  Alu_fun;
    logic        arith_enable, logic_enable, cmp_enable, shift_enable;
    logic [15:0] arith_out;
    logic        arith_flag, arith_flag_q;
    logic [7:0]  logic_out, shift_out;
    logic        logic_flag, logic_flag_q, cmp_flag, shift_flag;
    logic [2:0]  cmp_out;
    logic        res_valid, res_ready, res_err, busy;
    logic [15:0] res_data;

    logic [3:0]  resp_mask;
    logic        rogue_logic;

    int          n_checks, n_fail, en_run;
    logic [7:0]  cur_a, cur_b;
    logic [3:0]  cur_fun;
    logic [15:0] cur_exp_data;
    logic        cur_exp_err, cur_valid;

    alu_cmd_sequencer #(
        .In_Data_Width (8),
        .Out_Width     (16),
        .Timeout_Cycles(4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_A       (cmd_A),
        .cmd_B       (cmd_B),
        .cmd_fun     (cmd_fun),
        .A           (A),
        .B           (B),
        .Alu_fun     (Alu_fun),
        .arith_enable(arith_enable),
        .logic_enable(logic_enable),
        .cmp_enable  (cmp_enable),
        .shift_enable(shift_enable),
        .arith_out   (arith_out),
        .arith_flag  (arith_flag),
        .logic_out   (logic_out),
        .logic_flag  (logic_flag),
        .cmp_out     (cmp_out),
        .cmp_flag    (cmp_flag),
        .shift_out   (shift_out),
        .shift_flag  (shift_flag),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_data    (res_data),
        .res_err     (res_err),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // What each unit computes, already extended to the response width.
    function automatic logic [15:0] unit_calc(input logic [7:0] a, input logic [7:0] b,
                                              input logic [3:0] fun);
        logic signed [15:0] sa, sb;
        logic [15:0]        r;
        sa = {{8{a[7]}}, a};
        sb = {{8{b[7]}}, b};
        r  = 16'h0;
        case (fun[3:2])
            2'b00: case (fun[1:0])
                2'b00: r = sa + sb;
                2'b01: r = sa - sb;
                2'b10: r = sa * sb;
                default: r = -sa;
            endcase
            2'b01: case (fun[1:0])
                2'b00: r = {8'h00, a & b};
                2'b01: r = {8'h00, a | b};
                2'b10: r = {8'h00, a ^ b};
                default: r = {8'h00, ~a};
            endcase
            2'b10: r = {13'd0, $signed(a) > $signed(b), a == b, $signed(a) < $signed(b)};
            default: case (fun[1:0])
                2'b00: r = {8'h00, a[6:0], 1'b0};
                2'b01: r = {8'h00, 1'b0, a[7:1]};
                2'b10: r = {8'h00, a[6:0], a[7]};
                default: r = {8'h00, a[7], a[7:1]};
            endcase
        endcase
        return r;
    endfunction

    // Unit stubs: result and flag registered one cycle after the enable, if allowed to answer.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            arith_flag_q <= 1'b0;
            logic_flag_q <= 1'b0;
            cmp_flag     <= 1'b0;
            shift_flag   <= 1'b0;
            arith_out    <= 16'h0;
            logic_out    <= 8'h0;
            cmp_out      <= 3'h0;
            shift_out    <= 8'h0;
        end else begin
            arith_flag_q <= arith_enable & resp_mask[0];
            logic_flag_q <= logic_enable & resp_mask[1];
            cmp_flag     <= cmp_enable & resp_mask[2];
            shift_flag   <= shift_enable & resp_mask[3];
            arith_out    <= unit_calc(A, B, {2'b00, Alu_fun});
            logic_out    <= 8'(unit_calc(A, B, {2'b01, Alu_fun}));
            cmp_out      <= 3'(unit_calc(A, B, {2'b10, Alu_fun}));
            shift_out    <= 8'(unit_calc(A, B, {2'b11, Alu_fun}));
        end
    end
    assign arith_flag = arith_flag_q;
    assign logic_flag = logic_flag_q | rogue_logic;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [3:0] fun);
        logic rdy;
        bit   done;
        cmd_A     = a;
        cmd_B     = b;
        cmd_fun   = fun;
        cmd_valid = 1'b1;
        done      = 1'b0;
        for (int n = 0; n < 20 && !done; n++) begin
            @(negedge clk);
            rdy = cmd_ready;
            @(posedge clk);
            done = rdy;
        end
        #1;
        cmd_valid = 1'b0;
        if (!done) chk("accept", 0, 1);
        cur_a        = a;
        cur_b        = b;
        cur_fun      = fun;
        cur_exp_err  = !resp_mask[fun[3:2]];
        cur_exp_data = cur_exp_err ? 16'h0 : unit_calc(a, b, fun);
        cur_valid    = 1'b1;
    endtask

    task automatic wait_resp(output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!res_valid && lat < 20);
    endtask

    task automatic consume();
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        chk("consume_valid", res_valid, 0);
        chk("consume_ready", cmd_ready, 1);
        cur_valid = 1'b0;
    endtask

    task automatic run(input string name, input logic [7:0] a, input logic [7:0] b,
                       input logic [3:0] fun, input logic [15:0] exp_data, input logic exp_err,
                       input int exp_lat);
        int lat;
        send(a, b, fun);
        chk({name, "_enable"}, {shift_enable, cmp_enable, logic_enable, arith_enable},
            4'b0001 << fun[3:2]);
        chk({name, "_alu_fun"}, Alu_fun, fun[1:0]);
        chk({name, "_model_pin"}, {cur_exp_err, cur_exp_data}, {exp_err, exp_data});
        wait_resp(lat);
        chk({name, "_latency"}, lat, exp_lat);
        chk({name, "_data"}, res_data, exp_data);
        chk({name, "_err"}, res_err, exp_err);
        consume();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        en_run      = 0;
        cur_valid   = 1'b0;
        cur_a       = 8'h0;
        cur_b       = 8'h0;
        cur_fun     = 4'h0;
        cur_exp_data = 16'h0;
        cur_exp_err = 1'b0;
        rst         = 1'b0;
        cmd_valid   = 1'b0;
        cmd_A       = 8'h0;
        cmd_B       = 8'h0;
        cmd_fun     = 4'h0;
        res_ready   = 1'b0;
        resp_mask   = 4'b1111;
        rogue_logic = 1'b0;

        // Per-cycle compare against the transaction model.
        fork
            forever begin
                @(negedge clk);
                if (rst) begin
                    chk("cyc_onehot", $countones({shift_enable, cmp_enable, logic_enable,
                                                  arith_enable}) <= 1, 1);
                    if (arith_enable | logic_enable | cmp_enable | shift_enable) begin
                        en_run++;
                        chk("cyc_en_unit", {shift_enable, cmp_enable, logic_enable, arith_enable},
                            4'b0001 << cur_fun[3:2]);
                        chk("cyc_en_pulse", en_run, 1);
                        chk("cyc_ops", {A, B, Alu_fun}, {cur_a, cur_b, cur_fun[1:0]});
                    end else begin
                        en_run = 0;
                    end
                    if (res_valid && cur_valid)
                        chk("cyc_resp", {res_err, res_data}, {cur_exp_err, cur_exp_data});
                    chk("cyc_ready_busy", cmd_ready, !busy);
                end else begin
                    en_run = 0;
                end
            end
        join_none

        #12;
        chk("rst_ops", {A, B, Alu_fun}, 0);
        chk("rst_en", {arith_enable, logic_enable, cmp_enable, shift_enable}, 0);
        chk("rst_resp", {res_valid, res_err, res_data}, 0);
        chk("rst_busy", busy, 0);
        #2 rst = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_ready", cmd_ready, 1);

        run("and",   8'hF0, 8'h3C, 4'b0100, 16'h0030, 1'b0, 2);
        run("mul",   8'hFD, 8'h05, 4'b0010, 16'hFFF1, 1'b0, 2);
        run("or",    8'hF0, 8'h3C, 4'b0101, 16'h00FC, 1'b0, 2);
        run("add",   8'h7F, 8'h7F, 4'b0000, 16'h00FE, 1'b0, 2);
        run("sub",   8'h80, 8'h01, 4'b0001, 16'hFF7F, 1'b0, 2);
        run("cmp_lt", 8'hFD, 8'h05, 4'b1000, 16'h0001, 1'b0, 2);
        run("cmp_gt", 8'h05, 8'hFD, 4'b1000, 16'h0004, 1'b0, 2);
        run("shr",   8'h81, 8'h00, 4'b1101, 16'h0040, 1'b0, 2);
        run("rotl",  8'h81, 8'h00, 4'b1110, 16'h0003, 1'b0, 2);

        // Backpressure, with a competing command presented during RESP.
        begin
            int lat;
            send(8'hA5, 8'h0F, 4'b0110);
            wait_resp(lat);
            chk("bp_latency", lat, 2);
            cmd_A     = 8'h11;
            cmd_B     = 8'h33;
            cmd_fun   = 4'b0100;
            cmd_valid = 1'b1;
            for (int i = 0; i < 5; i++) begin
                @(posedge clk);
                #1;
                chk("bp_hold", {res_valid, res_err, res_data}, {1'b1, 1'b0, 16'h00AA});
                chk("bp_ready", cmd_ready, 0);
                chk("bp_ops", {A, B}, {8'hA5, 8'h0F});
            end
            res_ready = 1'b1;
            @(posedge clk);
            #1;
            res_ready = 1'b0;
            cur_valid = 1'b0;
            chk("bp_release", {res_valid, busy, logic_enable}, 3'b000);
            @(posedge clk);
            #1;
            cmd_valid    = 1'b0;
            cur_a        = 8'h11;
            cur_b        = 8'h33;
            cur_fun      = 4'b0100;
            cur_exp_err  = 1'b0;
            cur_exp_data = unit_calc(8'h11, 8'h33, 4'b0100);
            cur_valid    = 1'b1;
            chk("bp_next_accept", {logic_enable, A}, {1'b1, 8'h11});
            cmd_A = 8'hFF;
            cmd_B = 8'hFF;
            wait_resp(lat);
            chk("bp_next_latency", lat, 2);
            chk("bp_next_data", res_data, 16'h0011);
            consume();
        end

        resp_mask = 4'b0111;
        run("timeout", 8'h12, 8'h34, 4'b1100, 16'h0000, 1'b1, 5);
        resp_mask   = 4'b1011;
        rogue_logic = 1'b1;
        run("wrong_unit", 8'h12, 8'h34, 4'b1000, 16'h0000, 1'b1, 5);
        rogue_logic = 1'b0;

        // Reset in WAIT.
        resp_mask = 4'b0111;
        send(8'h01, 8'h02, 4'b1100);
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        cur_valid = 1'b0;
        chk("rstw_en", {arith_enable, logic_enable, cmp_enable, shift_enable}, 0);
        chk("rstw_valid_busy", {res_valid, busy}, 0);
        chk("rstw_ready", cmd_ready, 1);
        #3 rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rstw_idle", {cmd_ready, busy, res_valid}, 3'b100);
        run("after_rst_to", 8'h55, 8'h66, 4'b1100, 16'h0000, 1'b1, 5);
        resp_mask = 4'b1111;
        run("after_rst_add", 8'h01, 8'h02, 4'b0000, 16'h0003, 1'b0, 2);

        // Reset in RESP.
        begin
            int lat;
            send(8'hF0, 8'h0F, 4'b0101);
            wait_resp(lat);
            chk("rstr_latency", lat, 2);
            #3 rst = 1'b0;
            #1;
            cur_valid = 1'b0;
            chk("rstr_resp", {res_valid, busy, res_err, res_data}, 0);
            #3 rst = 1'b1;
        end
        @(posedge clk);
        #1;
        run("final_xor", 8'h3C, 8'hFF, 4'b0110, 16'h00C3, 1'b0, 2);

        disable fork;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
Front-end controller for the signed ALU.
- Accepts one command per valid/ready handshake and registers the operands.
- Decodes the 4-bit function code into one-cycle enables for the arithmetic, logic, compare and shift units.
- Waits for the selected unit's flag, captures and extends its result, and holds it on a valid/ready response port.
- Sits directly upstream of the execution units (drives their A, B, enable, Alu_fun) and downstream of their outputs.

Parameters:
In_Data_Width, 8, operand width in bits.
Out_Width, 2*In_Data_Width, response data width (full arithmetic product width).
Timeout_Cycles, 4, WAIT cycles tolerated before an error response; minimum 1.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous active-low reset.
cmd_valid  in  1  command present.
cmd_ready  out  1  sequencer can accept a command.
cmd_A  in  In_Data_Width  operand A, signed.
cmd_B  in  In_Data_Width  operand B, signed.
cmd_fun  in  4  [3:2] unit select (00 arith, 01 logic, 10 cmp, 11 shift); [1:0] unit sub-function.
A  out  In_Data_Width  registered operand A to all units.
B  out  In_Data_Width  registered operand B to all units.
Alu_fun  out  2  registered cmd_fun[1:0] to all units.
arith_enable, logic_enable, cmp_enable, shift_enable  out  1 each  unit enables, at most one high.
arith_out  in  Out_Width  signed arithmetic result.
arith_flag  in  1  arithmetic result valid.
logic_out  in  In_Data_Width  logic result.
logic_flag  in  1  logic result valid.
cmp_out  in  3  compare result.
cmp_flag  in  1  compare result valid.
shift_out  in  In_Data_Width  shift result.
shift_flag  in  1  shift result valid.
res_valid  out  1  response present.
res_ready  in  1  consumer accepts response.
res_data  out  Out_Width  extended result.
res_err  out  1  timeout occurred; res_data is 0.
busy  out  1  high in any state other than IDLE.

Behaviour:
Reset (rst low, asynchronous):
- State returns to IDLE.
- A, B, Alu_fun, all enables, res_valid, res_data, res_err and the timeout counter go to 0.
- cmd_ready = 1 once rst is released.
- Reset mid-operation abandons the command; no response is produced.

States: IDLE, ISSUE, WAIT, RESP. All outputs are registered or decoded from state; there is no combinational path from inputs to outputs.

IDLE:
- cmd_ready = 1.
- On cmd_valid at an edge: latch cmd_A→A, cmd_B→B, cmd_fun[1:0]→Alu_fun, and the unit select; go to ISSUE.

ISSUE (exactly 1 cycle):
- Only the selected unit's enable is high.
- A, B and Alu_fun are held stable.
- Go to WAIT; clear the timeout counter.

WAIT:
- All enables are low.
- If the selected unit's flag = 1: capture the result, set res_err = 0, go to RESP.
- Flags of non-selected units are ignored.
- Otherwise increment the counter. When the counter reaches Timeout_Cycles: res_data = 0, res_err = 1, go to RESP.

RESP:
- res_valid = 1; res_data and res_err are held stable.
- On res_ready: clear res_valid and go to IDLE.
- The next command is accepted no earlier than the following cycle; there is no overlap.

Extension rules:
- arith_out is taken as is.
- logic_out and shift_out are zero-extended to Out_Width.
- cmp_out is zero-extended to Out_Width.

Latency:
- Command accepted at edge k → enable high during cycle k..k+1.
- Unit-registered result and flag are visible during cycle k+1..k+2.
- res_valid is high after edge k+2 (2 cycles), provided the unit answers in 1 cycle.

Other rules:
- cmd_valid while not in IDLE: ignored; cmd_ready = 0.
- res_ready while res_valid = 0: no effect.
- Operands are not re-sampled after acceptance. Changing cmd_A or cmd_B during ISSUE, WAIT or RESP does not affect A, B or the response.

Test Plan:
1. Logic AND: cmd A=8'hF0, B=8'h3C, fun=4'b0100, logic-unit model → logic_enable high for exactly 1 cycle, Alu_fun=2'b00; res_valid 2 cycles after accept; res_data=16'h0030, res_err=0.
2. Signed arithmetic: A=-3 (8'hFD), B=5, fun=4'b0010 (multiply), unit model returns 16'hFFF1 → res_data=16'hFFF1; only arith_enable pulses.
3. Backpressure: response with res_ready held low for 5 cycles → res_valid and res_data stable for all 5; cmd_ready=0 throughout; a cmd_valid presented meanwhile is not accepted until the cycle after res_ready.
4. Timeout: fun=4'b1100 with shift_flag tied 0 → exactly Timeout_Cycles=4 WAIT cycles, then res_valid=1, res_err=1, res_data=0.
5. Wrong-unit flag: fun selects cmp, stub raises logic_flag only → no capture; timeout error response.
6. Reset mid-WAIT: assert rst low asynchronously between edges → all enables, res_valid and busy drop immediately; after release cmd_ready=1 and the next command completes normally with correct data.
